// File: rtl/fetch_queue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage_pkg
// Purpose  : Shared types, default constants and helpers for the fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_queue_stage_pkg;

  localparam int                      c_ADDR_WIDTH = 32;
  localparam int                      c_INST_WIDTH = 32;
  localparam logic [c_ADDR_WIDTH-1:0] c_RESET_PC   = '0;
  localparam int                      c_PC_STEP    = 4;
  localparam int                      c_BRANCH_BIT = 6;

  typedef struct packed {
    logic [c_ADDR_WIDTH-1:0] pc;
    logic [c_INST_WIDTH-1:0] inst;
    logic                    isBranch;
    logic                    predTaken;
    logic [c_ADDR_WIDTH-1:0] predTarget;
  } FetchQueueEntry;

  // Branch-class opcodes are identified by a single opcode bit.
  function automatic logic checkIfBranch(input logic [c_BRANCH_BIT:0] inst_low);
    return inst_low[c_BRANCH_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_fifo
// Purpose  : Circular-buffer instruction queue with push, pop, clear and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_pop;

  assign w_empty = (r_count == '0);
  assign w_pop   = pop && !w_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push)  r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_tail] <= push_data;
  end

  assign count      = r_count;
  assign head_valid = !w_empty;
  assign head_data  = w_empty ? '0 : r_mem[r_head];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Purpose  : Credit-based instruction fetch with prediction, redirect squash
//            and a decoupling instruction queue toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int                    INST_WIDTH  = c_INST_WIDTH,
  parameter int                    QUEUE_DEPTH = 4,
  parameter int                    PC_STEP     = c_PC_STEP,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(c_RESET_PC)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req_valid,
  output logic [ADDR_WIDTH-1:0]          imem_req_addr,
  input  logic                           imem_req_ready,
  input  logic [INST_WIDTH-1:0]          imem_resp_inst,
  input  logic                           bp_hit,
  input  logic [ADDR_WIDTH-1:0]          bp_target,
  input  logic                           bp_taken,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH-1:0]          redirect_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_WIDTH-1:0]          out_pc,
  output logic [INST_WIDTH-1:0]          out_inst,
  output logic                           out_is_branch,
  output logic                           out_pred_taken,
  output logic [ADDR_WIDTH-1:0]          out_pred_target,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int                    c_CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam int                    c_ENTRY_W = 2 * ADDR_WIDTH + INST_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] c_STEP    = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_infl_valid;
  logic [ADDR_WIDTH-1:0] r_infl_pc;
  logic                  r_infl_pred_taken;
  logic [ADDR_WIDTH-1:0] r_infl_pred_target;

  logic                  w_pop;
  logic [c_CW:0]         w_occ;
  logic                  w_accept;
  logic                  w_pred_taken;
  logic [ADDR_WIDTH-1:0] w_pred_target;
  logic                  w_push;
  logic [c_ENTRY_W-1:0]  w_push_data;
  logic [c_ENTRY_W-1:0]  w_head_data;

  assign w_pop = out_valid && out_ready;

  // Credits: queued + in-flight - leaving this cycle must leave room for one more.
  assign w_occ = {1'b0, queue_count} + (c_CW+1)'(r_infl_valid) - (c_CW+1)'(w_pop);
  assign imem_req_valid = !rst && !redirect_valid && (w_occ < (c_CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_pred_taken  = bp_hit && bp_taken;
  assign w_pred_target = w_pred_taken ? bp_target : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc               <= RESET_PC;
      r_infl_valid       <= 1'b0;
      r_infl_pc          <= '0;
      r_infl_pred_taken  <= 1'b0;
      r_infl_pred_target <= '0;
    end else if (redirect_valid) begin
      r_pc         <= redirect_pc;
      r_infl_valid <= 1'b0;
    end else if (w_accept) begin
      r_infl_valid       <= 1'b1;
      r_infl_pc          <= r_pc;
      r_infl_pred_taken  <= w_pred_taken;
      r_infl_pred_target <= w_pred_target;
      r_pc               <= w_pred_taken ? bp_target : r_pc + c_STEP;
    end else begin
      r_infl_valid <= 1'b0;
    end
  end

  // A response arriving in a redirect cycle belongs to the wrong path.
  assign w_push      = r_infl_valid && !redirect_valid;
  assign w_push_data = {r_infl_pc, imem_resp_inst, r_infl_pred_taken, r_infl_pred_target};

  fetch_queue_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_data  (w_push_data),
    .pop        (w_pop),
    .clear      (redirect_valid),
    .count      (queue_count),
    .head_valid (out_valid),
    .head_data  (w_head_data)
  );

  assign {out_pc, out_inst, out_pred_taken, out_pred_target} = w_head_data;
  assign out_is_branch = checkIfBranch(out_inst[6:0]);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_stage
// Purpose  : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic [IW-1:0] imem_resp_inst;
  logic          bp_hit;
  logic [AW-1:0] bp_target;
  logic          bp_taken;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic          out_is_branch;
  logic          out_pred_taken;
  logic [AW-1:0] out_pred_target;
  logic [CW-1:0] queue_count;

  fetch_queue_stage #(
    .ADDR_WIDTH (AW), .INST_WIDTH (IW), .QUEUE_DEPTH (D), .PC_STEP (4), .RESET_PC ('0)
  ) dut (
    .clk (clk), .rst (rst),
    .imem_req_valid (imem_req_valid), .imem_req_addr (imem_req_addr),
    .imem_req_ready (imem_req_ready), .imem_resp_inst (imem_resp_inst),
    .bp_hit (bp_hit), .bp_target (bp_target), .bp_taken (bp_taken),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .out_valid (out_valid), .out_ready (out_ready), .out_pc (out_pc),
    .out_inst (out_inst), .out_is_branch (out_is_branch),
    .out_pred_taken (out_pred_taken), .out_pred_target (out_pred_target),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending fetch plus an ordered list of queued instructions.
  FetchQueueEntry m_q[$];
  FetchQueueEntry m_infl_e;
  bit             m_infl;
  logic [AW-1:0]  m_pc;

  logic [AW-1:0]  acc_q[$];
  FetchQueueEntry pop_q[$];

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_1357;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_infl = 0;
    m_pc   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model after posedge.
  task automatic sim_cycle(input int rdy_pct, input int imem_pct, input int bp_mode,
                           input int redir_pct, input bit force_redir,
                           input logic [AW-1:0] force_pc);
    int             occ;
    bit             pop, acc, redir, pred, exp_rv;
    logic [AW-1:0]  rpc;
    FetchQueueEntry e;
    imem_resp_inst = m_infl ? inst_of(m_infl_e.pc) : $urandom;
    out_ready      = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < imem_pct);
    redir          = force_redir || ($urandom_range(99) < redir_pct);
    rpc            = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
    redirect_valid = redir;
    redirect_pc    = rpc;
    case (bp_mode)
      1: begin
        bp_hit = ($urandom_range(1) == 1); bp_taken = ($urandom_range(1) == 1);
        bp_target = 32'($urandom_range(255)) << 2;
      end
      2: begin bp_hit = (m_pc == 32'h8); bp_taken = 1'b1; bp_target = 32'h100; end
      default: begin
        bp_hit = 1'b0; bp_taken = ($urandom_range(1) == 1); bp_target = $urandom;
      end
    endcase
    @(negedge clk);
    pop    = (m_q.size() > 0) && out_ready;
    occ    = m_q.size() + int'(m_infl) - int'(pop);
    exp_rv = !redir && (occ < D);
    acc    = exp_rv && imem_req_ready;
    pred   = bp_hit && bp_taken;
    checks++; if (imem_req_valid !== exp_rv) begin errors++;
      $display("FAIL req_valid t=%0t got %0b want %0b", $time, imem_req_valid, exp_rv); end
    checks++; if (imem_req_addr !== m_pc) begin errors++;
      $display("FAIL req_addr t=%0t got %h want %h", $time, imem_req_addr, m_pc); end
    checks++; if (queue_count !== CW'(m_q.size())) begin errors++;
      $display("FAIL queue_count t=%0t got %0d want %0d", $time, queue_count, m_q.size()); end
    checks++; if (out_valid !== (m_q.size() > 0)) begin errors++;
      $display("FAIL out_valid t=%0t got %0b want %0b", $time, out_valid, m_q.size() > 0); end
    if (m_q.size() > 0) begin
      e = m_q[0];
      checks++; if ({out_pc, out_inst, out_is_branch, out_pred_taken, out_pred_target} !==
                    {e.pc, e.inst, e.isBranch, e.predTaken, e.predTarget}) begin
        errors++;
        $display("FAIL head t=%0t got pc=%h inst=%h br=%0b pt=%0b tgt=%h want pc=%h inst=%h br=%0b pt=%0b tgt=%h",
                 $time, out_pc, out_inst, out_is_branch, out_pred_taken, out_pred_target,
                 e.pc, e.inst, e.isBranch, e.predTaken, e.predTarget);
      end
    end
    if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
    if (out_valid && out_ready)
      pop_q.push_back(FetchQueueEntry'{pc: out_pc, inst: out_inst, isBranch: out_is_branch,
                                       predTaken: out_pred_taken, predTarget: out_pred_target});
    @(posedge clk); #1;
    if (redir) begin
      m_q.delete();
      m_infl = 0;
      m_pc   = rpc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) begin
        e          = m_infl_e;
        e.inst     = inst_of(e.pc);
        e.isBranch = e.inst[6];
        m_q.push_back(e);
      end
      if (acc) begin
        m_infl              = 1;
        m_infl_e            = '0;
        m_infl_e.pc         = m_pc;
        m_infl_e.predTaken  = pred;
        m_infl_e.predTarget = pred ? bp_target : '0;
        m_pc                = pred ? bp_target : m_pc + 32'd4;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 0; imem_req_ready = 0; imem_resp_inst = '0;
    bp_hit = 0; bp_taken = 0; bp_target = '0; redirect_valid = 0; redirect_pc = '0;
    @(posedge clk); #1;
    checks++; if ({out_valid, imem_req_valid, queue_count} !== '0) begin errors++;
      $display("FAIL reset_ctrl got v=%0b rv=%0b cnt=%0d want 0 0 0", out_valid, imem_req_valid, queue_count); end
    checks++; if ({out_pc, out_inst, out_pred_taken, out_pred_target, out_is_branch} !== '0) begin errors++;
      $display("FAIL reset_data got pc=%h inst=%h tgt=%h want zeros", out_pc, out_inst, out_pred_target); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++;
      $display("FAIL reset_pc got %h want 0", imem_req_addr); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    int first_pop = -1;
    acc_q.delete(); pop_q.delete();
    for (int i = 0; i < 20; i++) begin
      sim_cycle(100, 100, 0, 0, 0, '0);
      if (first_pop < 0 && pop_q.size() > 0) first_pop = i;
    end
    checks++; if (first_pop !== 2) begin errors++;
      $display("FAIL seq_latency got cycle %0d want 2", first_pop); end
    checks++; if (pop_q.size() !== 18) begin errors++;
      $display("FAIL seq_throughput got %0d pops want 18", pop_q.size()); end
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== 32'(4 * i)) begin errors++;
        $display("FAIL seq_req[%0d] got %h want %h", i, acc_q[i], 4 * i); end
    end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++; if (pop_q[i].pc !== 32'(4 * i)) begin errors++;
        $display("FAIL seq_pop[%0d] got %h want %h", i, pop_q[i].pc, 4 * i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    acc_q.delete();
    for (int i = 0; i < 8; i++) sim_cycle(0, 100, 0, 0, 0, '0);
    checks++; if (acc_q.size() !== D) begin errors++;
      $display("FAIL bp_accepts got %0d want %0d", acc_q.size(), D); end
    checks++; if (queue_count !== CW'(D) || imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL bp_full got cnt=%0d rv=%0b want %0d 0", queue_count, imem_req_valid, D); end
    pop_q.delete();
    for (int i = 0; i < 14; i++) sim_cycle(100, 100, 0, 0, 0, '0);
    checks++; if (pop_q.size() < 12) begin errors++;
      $display("FAIL bp_resume got %0d pops want >= 12", pop_q.size()); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++; if (pop_q[i].pc !== 32'(4 * i)) begin errors++;
        $display("FAIL bp_order[%0d] got %h want %h", i, pop_q[i].pc, 4 * i); end
    end
  endtask

  task automatic test_branch();
    bit seen8 = 0;
    do_reset();
    acc_q.delete(); pop_q.delete();
    for (int i = 0; i < 10; i++) sim_cycle(100, 100, 2, 0, 0, '0);
    checks++; if (acc_q.size() < 5 || acc_q[3] !== 32'h100 || acc_q[4] !== 32'h104) begin errors++;
      $display("FAIL br_next_req got n=%0d a3=%h want a3=100 a4=104", acc_q.size(),
               acc_q.size() > 3 ? acc_q[3] : 32'hx); end
    for (int i = 0; i < pop_q.size(); i++) begin
      if (pop_q[i].pc == 32'h8) begin
        seen8 = 1;
        checks++; if (pop_q[i].predTaken !== 1'b1 || pop_q[i].predTarget !== 32'h100) begin errors++;
          $display("FAIL br_head got pt=%0b tgt=%h want 1 100", pop_q[i].predTaken, pop_q[i].predTarget); end
        checks++; if (i + 1 >= pop_q.size() || pop_q[i+1].pc !== 32'h100) begin errors++;
          $display("FAIL br_follow got %h want 100", i + 1 < pop_q.size() ? pop_q[i+1].pc : 32'hx); end
      end else if (pop_q[i].pc == 32'h4) begin
        checks++; if (pop_q[i].predTaken !== 1'b0 || pop_q[i].predTarget !== 32'h0) begin errors++;
          $display("FAIL br_nottaken got pt=%0b tgt=%h want 0 0", pop_q[i].predTaken, pop_q[i].predTarget); end
      end
    end
    checks++; if (!seen8) begin errors++; $display("FAIL br_seen got 0 want 1"); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) sim_cycle(0, 100, 0, 0, 0, '0);
    checks++; if (queue_count !== CW'(3)) begin errors++;
      $display("FAIL rd_setup got cnt=%0d want 3", queue_count); end
    sim_cycle(0, 100, 0, 0, 1, 32'h200);
    checks++; if (queue_count !== '0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL rd_flush got cnt=%0d v=%0b want 0 0", queue_count, out_valid); end
    acc_q.delete(); pop_q.delete();
    for (int i = 0; i < 6; i++) sim_cycle(100, 100, 0, 0, 0, '0);
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h200) begin errors++;
      $display("FAIL rd_req got %h want 200", acc_q.size() > 0 ? acc_q[0] : 32'hx); end
    checks++; if (pop_q.size() == 0 || pop_q[0].pc !== 32'h200) begin errors++;
      $display("FAIL rd_out got %h want 200", pop_q.size() > 0 ? pop_q[0].pc : 32'hx); end
  endtask

  task automatic test_toggle();
    do_reset();
    pop_q.delete();
    for (int i = 0; i < 200; i++) sim_cycle(60, (i % 2 == 0) ? 100 : 0, 0, 0, 0, '0);
    checks++; if (pop_q.size() < 40) begin errors++;
      $display("FAIL tg_progress got %0d pops want >= 40", pop_q.size()); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++; if (pop_q[i].pc !== 32'(4 * i)) begin errors++;
        $display("FAIL tg_order[%0d] got %h want %h", i, pop_q[i].pc, 4 * i); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) sim_cycle(70, 70, 1, 4, 0, '0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) sim_cycle(50, 100, 0, 0, 0, '0);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || queue_count !== '0) begin errors++;
      $display("FAIL async_rst got v=%0b rv=%0b cnt=%0d want 0 0 0", out_valid, imem_req_valid, queue_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    acc_q.delete();
    for (int i = 0; i < 4; i++) sim_cycle(100, 100, 0, 0, 0, '0);
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h0) begin errors++;
      $display("FAIL async_restart got %h want 0", acc_q.size() > 0 ? acc_q[0] : 32'hx); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_redirect();
    test_toggle();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
